// File: rtl/code_line_decoder_if.sv
// Handshake and output bundle for the sequenced 3-to-8 line decoder.
// The producer side drives codes in; the decoder drives the line strobes out.
interface code_line_decoder_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_code;
    logic          in_none;
    logic [7:0]    out_line;
    logic          out_valid;
    logic          busy;
    logic [CW-1:0] count;

    // Producer / observer side.
    modport master (
        output in_valid, in_code, in_none,
        input  in_ready, out_line, out_valid, busy, count
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_code, in_none,
        output in_ready, out_line, out_valid, busy, count
    );
endinterface

// File: rtl/code_line_decoder.sv
// Sequenced 3-to-8 line decoder: buffers {none, code} entries in a small FIFO
// and replays each as a registered one-hot line held HOLD cycles, followed by
// one gap cycle and one idle cycle before the next pop.
module code_line_decoder #(
    parameter int HOLD  = 2,
    parameter int DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    code_line_decoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    logic [3:0]    fifo_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [3:0]    hold_q, hold_d;
    logic [7:0]    line_q, line_d;

    logic       full;
    logic       push;
    logic       pop;
    logic [3:0] head;
    logic [7:0] head_line;

    // Handshake decisions use only registered occupancy, so a pop never
    // frees a slot for a push in the same cycle.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        push      = bus.in_valid && !full;
        pop       = (state_q == IDLE) && (count_q != '0);
        head      = fifo_mem_q[rd_ptr_q];
        head_line = head[3] ? 8'h00 : (8'h01 << head[2:0]);
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
    end

    // Replay sequencer: IDLE pops, DRIVE holds the line, GAP blanks one cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        line_d  = line_q;
        unique case (state_q)
            IDLE: begin
                line_d = 8'h00;
                if (pop) begin
                    line_d  = head_line;
                    hold_d  = 4'(HOLD - 1);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (hold_q == 4'd0) begin
                    state_d = GAP;
                    line_d  = 8'h00;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
                line_d  = 8'h00;
            end
            default: begin
                state_d = IDLE;
                line_d  = 8'h00;
            end
        endcase
    end

    // Control state; reset clears the line immediately and discards entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            hold_q   <= 4'd0;
            line_q   <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            line_q   <= line_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {bus.in_none, bus.in_code};
    end

    assign bus.in_ready  = !full;
    assign bus.out_line  = line_q;
    assign bus.out_valid = (state_q == DRIVE);
    assign bus.busy      = (state_q != IDLE) || (count_q != '0);
    assign bus.count     = count_q;
endmodule

// File: tb/tb_code_line_decoder.sv
// Bench for code_line_decoder: a queue-based reference model is checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_code_line_decoder;
    localparam int HOLD  = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    code_line_decoder_if #(.DEPTH(DEPTH)) bus ();

    code_line_decoder #(.HOLD(HOLD), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending entries and the slot position of the
    // entry being replayed (-1 = idle; 0..HOLD-1 driving; HOLD = gap;
    // HOLD+1 = idle cycle that must pass before the next pop).
    logic [3:0] mq[$];
    int         mt = -1;
    logic [3:0] mcur = 4'h0;
    bit         m_push;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mt = -1;
        end else begin
            m_push = bus.in_valid && (mq.size() < DEPTH);
            if (mt >= 0) begin
                mt = mt + 1;
                if (mt > HOLD) mt = -1;
            end else if (mq.size() > 0) begin
                mcur = mq.pop_front();
                mt   = 0;
            end
            if (m_push) mq.push_back({bus.in_none, bus.in_code});
        end
    end

    function automatic bit m_valid();
        return (mt >= 0) && (mt < HOLD);
    endfunction

    function automatic int m_line();
        if (!m_valid() || mcur[3]) return 0;
        return 1 << mcur[2:0];
    endfunction

    // Per-cycle compare plus observation logs for directed scenarios.
    int   log_q[$];
    bit   prev_valid = 1'b0;
    bit   saw_full   = 1'b0;
    bit   any_valid  = 1'b0;

    always @(negedge clk) begin
        chk("m_out_valid", int'(bus.out_valid), int'(m_valid()));
        chk("m_out_line",  int'(bus.out_line),  m_line());
        chk("m_count",     int'(bus.count),     mq.size());
        chk("m_in_ready",  int'(bus.in_ready),  int'(mq.size() < DEPTH));
        chk("m_busy",      int'(bus.busy),      int'((mt >= 0) || (mq.size() > 0)));
        if (bus.out_valid && !prev_valid) log_q.push_back(int'(bus.out_line));
        prev_valid = bus.out_valid;
        if (bus.count == DEPTH && !bus.in_ready) saw_full = 1'b1;
        if (bus.out_valid) any_valid = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one entry, wait (bounded) for in_ready, then hold for one edge.
    task automatic push_one(input int code, input bit none);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = 3'(code);
        bus.in_none  = none;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("push_timeout", 0, 1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) chk("idle_timeout", 0, 1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;
        int prev;

        bus.in_valid = 1'b0;
        bus.in_code  = 3'd0;
        bus.in_none  = 1'b0;

        // Reset held two cycles with random inputs.
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_code  = 3'($urandom_range(0, 7));
            bus.in_none  = 1'($urandom_range(0, 1));
            step();
        end
        chk("rst_out_line",  int'(bus.out_line), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy",      int'(bus.busy), 0);
        chk("rst_count",     int'(bus.count), 0);
        chk("rst_in_ready",  int'(bus.in_ready), 1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("post_rst_busy", int'(bus.busy), 0);

        // Single code 5.
        push_one(5, 1'b0);
        step();
        chk("single_t1_line",  int'(bus.out_line), 'h20);
        chk("single_t1_valid", int'(bus.out_valid), 1);
        step();
        chk("single_t2_line",  int'(bus.out_line), 'h20);
        chk("single_t2_valid", int'(bus.out_valid), 1);
        step();
        chk("single_t3_line",  int'(bus.out_line), 0);
        chk("single_t3_valid", int'(bus.out_valid), 0);
        step();
        chk("single_t4_busy",  int'(bus.busy), 0);
        wait_idle();

        // Burst 7..0 as fast as in_ready allows.
        log_q.delete();
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) push_one(7 - i, 1'b0);
        wait_idle();
        chk("burst_saw_full", int'(saw_full), 1);
        chk("burst_log_len", log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            chk("burst_log_val", log_q[i], 'h80 >> i);

        // Empty slot followed by code 3.
        push_one(3, 1'b1);
        push_one(3, 1'b0);
        chk("none_t1_valid", int'(bus.out_valid), 1);
        chk("none_t1_line",  int'(bus.out_line), 0);
        step();
        chk("none_t2_valid", int'(bus.out_valid), 1);
        chk("none_t2_line",  int'(bus.out_line), 0);
        step();
        chk("none_gap_valid", int'(bus.out_valid), 0);
        step();
        chk("none_idle_valid", int'(bus.out_valid), 0);
        step();
        chk("code3_t1_line", int'(bus.out_line), 'h08);
        step();
        chk("code3_t2_line", int'(bus.out_line), 'h08);
        wait_idle();

        // Full FIFO with a held push across the cycle of a pop.
        log_q.delete();
        for (int c = 1; c <= 5; c++) push_one(c, 1'b0);
        chk("fp_full_count", int'(bus.count), DEPTH);
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd6;
        bus.in_none  = 1'b0;
        found = 1'b0;
        prev  = int'(bus.count);
        n     = 0;
        while (!found && n < 50) begin
            step();
            n++;
            if (prev == DEPTH && int'(bus.count) == DEPTH - 1) found = 1'b1;
            prev = int'(bus.count);
        end
        chk("fp_refused_on_pop", int'(found), 1);
        step();
        chk("fp_accept_count", int'(bus.count), DEPTH);
        bus.in_valid = 1'b0;
        wait_idle();
        chk("fp_log_len", log_q.size(), 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            chk("fp_log_val", log_q[i], 'h02 << i);

        // Reset mid-DRIVE with three entries queued.
        for (int c = 0; c <= 4; c++) push_one(c, 1'b0);
        n = 0;
        while (int'(bus.out_line) != 'h02 && n < 50) begin
            step();
            n++;
        end
        chk("mid_line_seen", int'(bus.out_line), 'h02);
        chk("mid_count", int'(bus.count), 3);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_line",  int'(bus.out_line), 0);
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_count", int'(bus.count), 0);
        step();
        rst = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("mid_no_stale", int'(any_valid), 0);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = ($urandom_range(0, 2) != 0);
            bus.in_code  = 3'($urandom_range(0, 7));
            bus.in_none  = ($urandom_range(0, 5) == 0);
            step();
        end
        bus.in_valid = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/code_line_decoder.md
# code_line_decoder

Sequenced 3-to-8 line decoder, the consumer-side counterpart of the team's 8-input priority encoder. It accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO. Each code is replayed as a registered one-hot 8-bit line, held for a programmable number of cycles and followed by one idle gap cycle. It sits between the encoder/arbiter stage and downstream per-line strobes (enables, interrupt acks, LED drivers).

## Interface
- HOLD, 2: cycles each one-hot pattern is driven; legal 1..15.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low: asserted at 0, released at 1. Reset is asynchronous and active-low.
- in_valid  input  1  producer has a code on in_code/in_none.
- in_ready  output  1  FIFO can accept; equals !full.
- in_code  input  3  code to decode; 0 maps to bit 0, 7 maps to bit 7.
- in_none  input  1  when 1, the entry is an "empty slot" and drives all-zero lines for HOLD cycles; in_code is ignored.
- out_line  output  8  registered one-hot line (or 0).
- out_valid  output  1  high while a pattern slot is being driven.
- busy  output  1  (state != IDLE) || (count != 0).
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Push: at a clk edge with in_valid && in_ready, {in_none, in_code} is written to the FIFO tail and count increments.
- in_ready is computed from the current count only. When the FIFO is full, a same-cycle pop does not open a slot; the push is refused and the producer must hold the values.
- FSM states:
  - IDLE: out_valid=0, out_line=0. If count>0, pop the head at the next edge, load out_line = in_none ? 8'h00 : (8'h01 << code), load the hold counter with HOLD-1, and go to DRIVE.
  - DRIVE: out_valid=1 and out_line is held. Decrement the counter each edge. When the counter is 0, go to GAP at the next edge and clear out_line and out_valid.
  - GAP: out_valid=0, out_line=0 for exactly one cycle, then go to IDLE.
- Push and pop in the same edge, when not full: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Entries are replayed strictly in FIFO order. There is no reordering by priority.
- out_line is never more than one-hot. It is all-zero whenever out_valid=0.

## Timing
- Reset values: out_line=8'h00, out_valid=0, busy=0, count=0, in_ready=1, state=IDLE. The FIFO is logically emptied and pending entries are discarded.
- Reset takes effect immediately on assertion, independent of clk. Asserting it mid-DRIVE drops out_line the same instant.
- Latency with an empty FIFO and FSM in IDLE:
  - push at edge T;
  - pop and out_valid=1 from edge T+1;
  - out_valid stays high for HOLD cycles (edges T+1 .. T+HOLD);
  - GAP starts at edge T+HOLD+1;
  - IDLE resumes at edge T+HOLD+2, where the next pop can occur.
- Sustained throughput: one entry per HOLD+2 cycles. There is no IDLE-bypass.
- HOLD=1: exactly one cycle in DRIVE.
- busy falls at the edge entering IDLE with count=0.
- in_ready rises the edge after a pop from a full FIFO.

## Test plan
- Reset: hold rst=0 for 2 cycles with random inputs. Required: out_line=0x00, out_valid=0, busy=0, count=0, in_ready=1. Release; with no pushes, outputs stay idle.
- Single code, HOLD=2: push code 5 at edge T. Required: out_line=0x20 and out_valid=1 after edges T+1 and T+2; 0x00 and 0 after edge T+3; busy=0 after edge T+4.
- Burst of codes 7,6,5,4,3,2,1,0 pushed as fast as in_ready allows (DEPTH=4):
  - count reaches 4 and in_ready=0 while full;
  - out_line sequence is 0x80,0x40,0x20,0x10,0x08,0x04,0x02,0x01;
  - each value lasts HOLD cycles, separated by exactly one 0x00/out_valid=0 cycle.
- Empty slot: push in_none=1 with in_code=3, then code 3. Required: HOLD cycles of out_valid=1 with out_line=0x00, then the gap, then 0x08 for HOLD cycles.
- Full-plus-pop: fill 4 entries and hold in_valid with code 6 through the cycle in which a pop occurs. Required: not accepted that cycle (count 4→3). Accepted next edge (count 3→4). Code 6 later appears as 0x40 in order.
- Reset mid-operation: 3 entries queued and DRIVE showing 0x02; drop rst between edges. Required: out_line=0x00 and out_valid=0 before the next edge, and count=0. After release, no stale code is ever emitted.
